// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-lite subordinate fronting a word-organised on-chip SRAM.
// Supports pipelined address and data phases, WAIT_STATES wait cycles per OKAY
// transfer, byte-lane writes, a two-cycle ERROR response and read-after-write
// forwarding.
// Optional feature macro: AHB_SLV_PROT_CHECK_EN. When it is defined, a user-mode
// write (HPROT[1]=0) to the upper half of the SRAM gets an ERROR response.
// Ports:
//   clk, HRESETn                      clock and asynchronous active-low reset
//   HSEL, HADDR, HWRITE, HSIZE,       address-phase controls
//   HBURST, HPROT, HTRANS, HREADY
//   HWDATA                            write data (data phase)
//   HREADYOUT, HRESP, HRDATA          registered data-phase response
module ahb_lite_sram_slave #(
  parameter int unsigned           addr_width  = 32,
  parameter int unsigned           data_width  = 32,
  parameter int unsigned           MEM_DEPTH   = 256,
  parameter logic [addr_width-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [addr_width-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  input  logic [data_width-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [data_width-1:0] HRDATA
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned OFF_W = IDX_W + 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LANES = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    wr_q;
  logic [IDX_W-1:0]        idx_q;
  logic [LANES-1:0]        be_q;
  logic                    hreadyout_q;
  logic                    hresp_q;
  logic [data_width-1:0]   hrdata_q;
  logic [data_width-1:0]   mem_q [MEM_DEPTH];

  logic                    accept;
  logic                    in_range;
  logic                    size_err;
  logic                    align_err;
  logic                    prot_err;
  logic                    err;
  logic                    wr_fire;
  logic [IDX_W-1:0]        idx;
  logic [LANES-1:0]        be;
  logic [data_width-1:0]   rd_word;
  logic                    unused_inputs;

  // Address-phase decode
  assign accept    = HSEL & HREADY & HTRANS[1];
  assign idx       = HADDR[OFF_W-1:2];
  assign in_range  = (HADDR[addr_width-1:OFF_W] == BASE_ADDR[addr_width-1:OFF_W]);
  assign size_err  = (HSIZE > 3'b010);
  assign align_err = ((HSIZE == 3'b001) & HADDR[0]) |
                     ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));

`ifdef AHB_SLV_PROT_CHECK_EN
  // User-mode writes may not touch the upper half of the array
  assign prot_err = HWRITE & ~HPROT[1] & (idx >= IDX_W'(MEM_DEPTH / 2));
`else
  assign prot_err = 1'b0;
`endif

  assign err           = ~in_range | size_err | align_err | prot_err;
  assign unused_inputs = ^{HBURST, HPROT, HTRANS[0]};

  // Little-endian byte enables
  always_comb begin
    be = '0;
    case (HSIZE)
      3'b000:  be[HADDR[1:0]] = 1'b1;
      3'b001:  be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // The write data phase completes on the edge that leaves DATA
  assign wr_fire = (state_q == S_DATA) & wr_q;

  // Read word with the lanes of a completing write to the same word forwarded
  always_comb begin
    rd_word = mem_q[idx];
    if (wr_fire && (idx_q == idx)) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (be_q[l]) rd_word[8*l +: 8] = HWDATA[8*l +: 8];
      end
    end
  end

  // SRAM array, not reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (be_q[l]) mem_q[idx_q][8*l +: 8] <= HWDATA[8*l +: 8];
      end
    end
  end

  // Transfer FSM with registered responses
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      be_q        <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= S_DATA;
            hreadyout_q <= 1'b1;
            if (!wr_q) hrdata_q <= mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all have HREADYOUT=1 and share the accept rules
          if (accept) begin
            idx_q <= idx;
            be_q  <= be;
            wr_q  <= HWRITE & ~err;
            cnt_q <= CNT_LOAD;
            if (err) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_q     <= S_WAIT;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
            end else begin
              state_q     <= S_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
              if (!HWRITE) hrdata_q <= rd_word;
            end
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: a zero-wait instance and a two-wait-state
// instance share one bus; dsel picks the active one.
module tb_ahb_lite_sram_slave;

  localparam int MEM_BYTES = 1024;
  localparam logic [3:0] PRIV = 4'b0011;
  localparam logic [3:0] USER = 4'b0001;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [1:0]  trans;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          waits;
    logic        wresp;
  } res_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic        dsel;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        sel0, sel2, hready_bus, hresp_bus;
  logic        ro0, rs0, ro2, rs2;
  logic [31:0] rd0, rd2, hrdata_bus;

  int errors = 0;
  int checks = 0;

  xfer_t       q[$];
  res_t        rs[];
  vec_t        tv[$];
  logic [7:0]  mb [2][MEM_BYTES];

  always #5 clk = ~clk;

  assign sel0       = HSEL & ~dsel;
  assign sel2       = HSEL & dsel;
  assign hready_bus = dsel ? ro2 : ro0;
  assign hresp_bus  = dsel ? rs2 : rs0;
  assign hrdata_bus = dsel ? rd2 : rd0;

  ahb_lite_sram_slave #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HREADY(hready_bus), .HWDATA(HWDATA),
    .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
  );

  ahb_lite_sram_slave #(.WAIT_STATES(2)) u_ws2 (
    .clk(clk), .HRESETn(HRESETn), .HSEL(sel2), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HREADY(hready_bus), .HWDATA(HWDATA),
    .HREADYOUT(ro2), .HRESP(rs2), .HRDATA(rd2)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic xfer_t mkx(logic [31:0] a, logic w, logic [2:0] s, logic [3:0] p,
                                logic [31:0] wd, logic [1:0] t);
    xfer_t x;
    x.addr = a; x.wr = w; x.size = s; x.prot = p; x.wdata = wd; x.trans = t;
    return x;
  endfunction

  function automatic vec_t mkv(logic [31:0] a, logic w, logic [2:0] s, logic [3:0] p,
                               logic [31:0] wd, logic e, logic c, logic [31:0] rd);
    vec_t v;
    v.addr = a; v.wr = w; v.size = s; v.prot = p; v.wdata = wd;
    v.exp_err = e; v.chk_rd = c; v.exp_rdata = rd;
    return v;
  endfunction

  // Reference decode: window is [0, 1024), size and alignment rules
  function automatic logic model_err(xfer_t x);
    logic e;
    int   nbytes;
    nbytes = 1 << x.size;
    e = (x.addr >= 32'(MEM_BYTES)) || (x.size > 3'd2) ||
        (x.size <= 3'd2 && (int'(x.addr) % nbytes) != 0);
`ifdef AHB_SLV_PROT_CHECK_EN
    if (x.wr && !x.prot[1] && x.addr >= 32'(MEM_BYTES / 2)) e = 1'b1;
`endif
    return e;
  endfunction

  // Pipelined AHB master: presents q in order, records every data phase
  task automatic run_bus();
    int ai, di, waits, cyc;
    logic wresp;
    ai = 0; di = -1; waits = 0; wresp = 1'b0; cyc = 0;
    rs = new[q.size()];
    foreach (rs[i]) begin
      rs[i].resp = 1'b0; rs[i].rdata = '0; rs[i].waits = -1; rs[i].wresp = 1'b0;
    end
    @(posedge clk); #1;
    while ((ai < q.size() || di >= 0) && cyc < 4000) begin
      if (ai < q.size()) begin
        HSEL = 1'b1; HADDR = q[ai].addr; HWRITE = q[ai].wr; HSIZE = q[ai].size;
        HPROT = q[ai].prot; HTRANS = q[ai].trans;
      end else begin
        HSEL = 1'b0; HTRANS = 2'b00;
      end
      if (di >= 0) HWDATA = q[di].wdata;
      @(negedge clk);
      if (di >= 0) begin
        if (!hready_bus) begin
          waits++;
          wresp = wresp | hresp_bus;
        end else begin
          rs[di].resp = hresp_bus; rs[di].rdata = hrdata_bus;
          rs[di].waits = waits;    rs[di].wresp = wresp;
        end
      end
      if (hready_bus) begin
        waits = 0; wresp = 1'b0;
        if (ai < q.size()) begin
          di = q[ai].trans[1] ? ai : -1;
          ai++;
        end else begin
          di = -1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    HSEL = 1'b0; HTRANS = 2'b00;
    check32("bus_timeout", 32'(cyc >= 4000), 32'd0);
  endtask

  // Compare recorded responses against the byte-array memory model
  task automatic check_model(input int d, input int ws, input string tag);
    for (int i = 0; i < q.size(); i++) begin
      logic        e;
      logic [31:0] w;
      int          base;
      if (!q[i].trans[1]) continue;
      e = model_err(q[i]);
      check32($sformatf("%s[%0d].resp", tag, i), {31'b0, rs[i].resp}, {31'b0, e});
      check32($sformatf("%s[%0d].waits", tag, i), 32'(rs[i].waits), e ? 32'd1 : 32'(ws));
      check32($sformatf("%s[%0d].wresp", tag, i), {31'b0, rs[i].wresp}, {31'b0, e});
      if (!e) begin
        if (q[i].wr) begin
          for (int b = 0; b < (1 << q[i].size); b++) begin
            int a;
            int lane;
            a = int'(q[i].addr) + b;
            lane = a % 4;
            mb[d][a] = q[i].wdata[8*lane +: 8];
          end
        end else begin
          base = int'(q[i].addr) & ~3;
          w = {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
          check32($sformatf("%s[%0d].rdata", tag, i), rs[i].rdata, w);
        end
      end
    end
  endtask

  task automatic random_run(input int d, input int ws);
    xfer_t x;
    int    r;
    dsel = d[0];
    q.delete();
    for (int i = 0; i < MEM_BYTES / 4; i++) q.push_back(mkx(32'(4*i), 1'b1, 3'd2, PRIV, $urandom, 2'b10));
    run_bus();
    check_model(d, ws, $sformatf("pre%0d", d));
    q.delete();
    for (int i = 0; i < 150; i++) begin
      x.addr  = 32'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom_range(0, 15) == 0) x.addr = 32'(MEM_BYTES) + 32'($urandom_range(0, 4095));
      x.size  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if (x.size <= 3'd2 && $urandom_range(0, 3) != 0) x.addr = x.addr & ~32'((1 << x.size) - 1);
      x.wr    = 1'($urandom_range(0, 1));
      x.prot  = 4'($urandom);
      x.wdata = $urandom;
      r = $urandom_range(0, 7);
      x.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 5) ? 2'b10 : 2'b11;
      q.push_back(x);
    end
    run_bus();
    check_model(d, ws, $sformatf("rnd%0d", d));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    HRESETn = 1'b0; HSEL = 1'b0; dsel = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd0;
    HBURST = 3'd0; HPROT = PRIV; HTRANS = 2'b00; HWDATA = '0;

    // Directed vectors on the zero-wait instance, issued back-to-back
    tv.push_back(mkv(32'h10,  1, 3'd2, PRIV, 32'hDEADBEEF, 0, 0, 0));
    tv.push_back(mkv(32'h10,  0, 3'd2, PRIV, 32'h0,        0, 1, 32'hDEADBEEF));
    tv.push_back(mkv(32'h20,  1, 3'd0, PRIV, 32'h00000011, 0, 0, 0));
    tv.push_back(mkv(32'h21,  1, 3'd0, PRIV, 32'h00002200, 0, 0, 0));
    tv.push_back(mkv(32'h22,  1, 3'd0, PRIV, 32'h00330000, 0, 0, 0));
    tv.push_back(mkv(32'h23,  1, 3'd0, PRIV, 32'h44000000, 0, 0, 0));
    tv.push_back(mkv(32'h20,  0, 3'd2, PRIV, 32'h0,        0, 1, 32'h44332211));
    tv.push_back(mkv(32'h400, 0, 3'd2, PRIV, 32'h0,        1, 0, 0));
    tv.push_back(mkv(32'h01,  0, 3'd1, PRIV, 32'h0,        1, 0, 0));
    tv.push_back(mkv(32'h10,  0, 3'd2, PRIV, 32'h0,        0, 1, 32'hDEADBEEF));
    tv.push_back(mkv(32'h30,  1, 3'd2, PRIV, 32'h12345678, 0, 0, 0));
    tv.push_back(mkv(32'h32,  1, 3'd1, PRIV, 32'hAABBCCDD, 0, 0, 0));
    tv.push_back(mkv(32'h30,  0, 3'd2, PRIV, 32'h0,        0, 1, 32'hAABB5678));
    tv.push_back(mkv(32'h30,  0, 3'd3, PRIV, 32'h0,        1, 0, 0));
    tv.push_back(mkv(32'h12,  1, 3'd2, PRIV, 32'hFFFFFFFF, 1, 0, 0));
    tv.push_back(mkv(32'h12,  1, 3'd1, PRIV, 32'h77660000, 0, 0, 0));
    tv.push_back(mkv(32'h11,  0, 3'd0, PRIV, 32'h0,        0, 1, 32'h7766BEEF));
    tv.push_back(mkv(32'h3FC, 1, 3'd2, PRIV, 32'hA5A5A5A5, 0, 0, 0));
`ifdef AHB_SLV_PROT_CHECK_EN
    tv.push_back(mkv(32'h3FC, 1, 3'd2, USER, 32'h5A5A5A5A, 1, 0, 0));
    tv.push_back(mkv(32'h3FC, 0, 3'd2, USER, 32'h0,        0, 1, 32'hA5A5A5A5));
`else
    tv.push_back(mkv(32'h3FC, 1, 3'd2, USER, 32'h5A5A5A5A, 0, 0, 0));
    tv.push_back(mkv(32'h3FC, 0, 3'd2, USER, 32'h0,        0, 1, 32'h5A5A5A5A));
`endif
    tv.push_back(mkv(32'h3FC, 1, 3'd2, PRIV, 32'hC3C3C3C3, 0, 0, 0));
    tv.push_back(mkv(32'h3FC, 0, 3'd2, PRIV, 32'h0,        0, 1, 32'hC3C3C3C3));

    repeat (3) @(posedge clk);
    #1;
    check32("rst_ready0", {31'b0, ro0}, 32'd1);
    check32("rst_resp0",  {31'b0, rs0}, 32'd0);
    check32("rst_rdata0", rd0, 32'd0);
    check32("rst_ready2", {31'b0, ro2}, 32'd1);
    check32("rst_resp2",  {31'b0, rs2}, 32'd0);
    check32("rst_rdata2", rd2, 32'd0);
    @(negedge clk); HRESETn = 1'b1;

    dsel = 1'b0;
    q.delete();
    foreach (tv[i]) q.push_back(mkx(tv[i].addr, tv[i].wr, tv[i].size, tv[i].prot, tv[i].wdata, 2'b10));
    run_bus();
    for (int i = 0; i < tv.size(); i++) begin
      check32($sformatf("vec[%0d].resp", i), {31'b0, rs[i].resp}, {31'b0, tv[i].exp_err});
      check32($sformatf("vec[%0d].waits", i), 32'(rs[i].waits), tv[i].exp_err ? 32'd1 : 32'd0);
      check32($sformatf("vec[%0d].wresp", i), {31'b0, rs[i].wresp}, {31'b0, tv[i].exp_err});
      if (tv[i].chk_rd) check32($sformatf("vec[%0d].rdata", i), rs[i].rdata, tv[i].exp_rdata);
    end

    // INCR4 read on the two-wait-state instance
    dsel = 1'b1; HBURST = 3'b011;
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(mkx(32'(32'h40 + 4*i), 1'b1, 3'd2, PRIV, 32'h1000_0001 * (i + 1), 2'b10));
    for (int i = 0; i < 4; i++) q.push_back(mkx(32'(32'h40 + 4*i), 1'b0, 3'd2, PRIV, 32'h0, (i == 0) ? 2'b10 : 2'b11));
    run_bus();
    total = 0;
    for (int i = 4; i < 8; i++) begin
      check32($sformatf("burst[%0d].waits", i - 4), 32'(rs[i].waits), 32'd2);
      check32($sformatf("burst[%0d].resp", i - 4), {31'b0, rs[i].resp}, 32'd0);
      check32($sformatf("burst[%0d].rdata", i - 4), rs[i].rdata, 32'h1000_0001 * (i - 3));
      total += rs[i].waits + 1;
    end
    check32("burst_total_cycles", 32'(total), 32'd12);
    HBURST = 3'b000;

    // Reset during the wait state of a write drops the write
    q.delete();
    q.push_back(mkx(32'h80, 1'b1, 3'd2, PRIV, 32'hCAFEF00D, 2'b10));
    run_bus();
    check32("pre_rst_write_resp", {31'b0, rs[0].resp}, 32'd0);
    HSEL = 1'b1; HADDR = 32'h80; HWRITE = 1'b1; HSIZE = 3'd2; HPROT = PRIV; HTRANS = 2'b10;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0BADBEEF;
    @(negedge clk);
    check32("rst_wait_entered", {31'b0, ro2}, 32'd0);
    HRESETn = 1'b0;
    #1;
    check32("rst_mid_ready", {31'b0, ro2}, 32'd1);
    check32("rst_mid_resp",  {31'b0, rs2}, 32'd0);
    check32("rst_mid_rdata", rd2, 32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); HRESETn = 1'b1;
    q.delete();
    q.push_back(mkx(32'h80, 1'b0, 3'd2, PRIV, 32'h0, 2'b10));
    run_bus();
    check32("post_rst_rdata", rs[0].rdata, 32'hCAFEF00D);
    check32("post_rst_waits", 32'(rs[0].waits), 32'd2);

    random_run(0, 0);
    random_run(1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-lite subordinate (responder) for the team's `ahb_lite` master.
- Fronts a word-organised on-chip SRAM with a pipelined address/data phase, programmable wait states, byte-lane writes and a two-cycle ERROR response.
- Sits on the master's bus behind the address decoder (HSEL) and is the default target for master bring-up and burst regression.

Parameters:
- addr_width, 32, HADDR width.
- data_width, 32, HWDATA/HRDATA width; fixed at 32 (4 byte lanes).
- MEM_DEPTH, 256, number of data_width words in the SRAM.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to MEM_DEPTH*4.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase (0..15).

Ports:
- clk  input  1  global clock, all state on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL  input  1  slave select from decoder.
- HADDR  input  addr_width  byte address.
- HWRITE  input  1  1 = write, 0 = read.
- HSIZE  input  3  transfer size.
- HBURST  input  3  burst type; informational only, not used for decode.
- HPROT  input  4  protection; HPROT[1] = privileged.
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HREADY  input  1  bus-level ready (muxed HREADYOUT of all slaves).
- HWDATA  input  data_width  write data, data phase.
- HREADYOUT  output  1  this slave's ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.
- HRDATA  output  data_width  read data, valid when HREADYOUT=1 and HRESP=0 in a read data phase.

Behaviour:
- Clock is `clk`; reset is `HRESETn`, asynchronous assert and active-low.
- Reset state: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, pending-write register cleared.
  - SRAM contents are not reset.
  - Reset mid-transfer drops any pending write.
- Address phase accepted when HSEL & HREADY & HTRANS[1] at a rising clk edge.
  - HADDR/HWRITE/HSIZE are latched at that edge.
  - HTRANS IDLE or BUSY, or HSEL=0: no access; next data phase is zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Error decode at the accept edge; any of the following gives ERROR:
  - address outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*4-1];
  - HSIZE > 3'b010;
  - misaligned access (HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]≠0).
- FSM states:
  - IDLE: no data phase outstanding. On accept, go to WAIT if WAIT_STATES>0 and no error, to ERR1 if error, otherwise to DATA.
  - WAIT: HREADYOUT=0, HRESP=0. Counts WAIT_STATES cycles, then goes to DATA.
  - DATA: HREADYOUT=1, HRESP=0. On a new accept in the same cycle, re-enter per the IDLE rules (back-to-back pipelining); otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Goes to IDLE. HREADY=1 in this cycle, so a new address phase may be accepted and is processed as from IDLE. No SRAM access occurs for the errored transfer.
- Write path:
  - HWDATA is sampled on the edge that ends DATA (HREADYOUT=1).
  - Byte enables are little-endian:
    - HSIZE=0: lane HADDR[1:0].
    - HSIZE=1: lanes {HADDR[1],0} and {HADDR[1],1}.
    - HSIZE=2: all four lanes.
  - Unselected lanes are unchanged.
- Read path:
  - The SRAM word is read at the entry edge of DATA and registered into HRDATA.
  - HRDATA always returns the full word regardless of HSIZE; the master extracts the lanes.
  - Zero-wait read latency is one cycle after the accept edge.
  - HRDATA holds its last value outside read data phases.
- RAW hazard: if a read is accepted in the cycle a write data phase completes to the same word, HRDATA returns the SRAM word with the written lanes replaced by HWDATA.
- Wait counter is 4 bits; it reloads on every accept and never wraps mid-phase.
- HBURST is ignored; SEQ beats are decoded independently, so wrapping bursts work by address alone.

Optional Feature:
- Macro: AHB_SLV_PROT_CHECK_EN.
- Defined: a write with HPROT[1]=0 (user mode) to the upper half of the SRAM (word index ≥ MEM_DEPTH/2) takes the ERR1/ERR2 path and the SRAM is unchanged. Reads are unaffected.
- Undefined: HPROT is ignored entirely.

Test Plan:
- WAIT_STATES=0: NONSEQ write 32'hDEADBEEF to 0x10, then NONSEQ read 0x10 back-to-back -> read data phase has HREADYOUT=1, HRDATA=32'hDEADBEEF via the RAW forward.
- Byte writes: HSIZE=0 writes 8'h11/22/33/44 to 0x20..0x23, then a word read of 0x20 -> HRDATA=32'h44332211.
- WAIT_STATES=2: INCR4 read from 0x40 -> each beat has exactly 2 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1; 12 cycles total data phases.
- Read of BASE_ADDR+MEM_DEPTH*4 and HSIZE=1 at 0x01 -> each gives HREADYOUT 0 then 1 with HRESP=1 both cycles; the next OKAY transfer after ERR2 completes normally.
- Assert HRESETn low during a WAIT-state write to 0x80 -> HREADYOUT=1, HRESP=0 immediately; a subsequent read of 0x80 returns the prior contents.
- With AHB_SLV_PROT_CHECK_EN: HPROT=4'b0001 write to word MEM_DEPTH-1 -> ERROR and word unchanged; HPROT=4'b0011 -> OKAY and word updated.
